// File: rtl/vend_session_arbiter_pkg.sv
// Shared definitions for the vending session arbiter and the VendingMachine core it fronts.
// Contents: arbiter FSM state type, bus field widths, the core's idle state code,
// product codes understood by the core, and the refund rule for aborted sessions.
package vend_session_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StStart,
    StWait,
    StAbort,
    StDone
  } arb_state_e;

  localparam int unsigned ProductWidth = 3;
  localparam int unsigned CoinWidth    = 7;
  localparam int unsigned VmStateWidth = 4;
  localparam int unsigned TimerWidth   = 8;

  localparam logic [VmStateWidth-1:0] VM_IDLE_STATE = '0;

  // Product codes shared with the VendingMachine core.
  localparam logic [ProductWidth-1:0] PRODUCT_NONE   = 3'd0;
  localparam logic [ProductWidth-1:0] PRODUCT_WATER  = 3'd1;
  localparam logic [ProductWidth-1:0] PRODUCT_COLA   = 3'd2;
  localparam logic [ProductWidth-1:0] PRODUCT_JUICE  = 3'd3;
  localparam logic [ProductWidth-1:0] PRODUCT_COFFEE = 3'd4;
  localparam logic [ProductWidth-1:0] PRODUCT_TEA    = 3'd5;
  localparam logic [ProductWidth-1:0] PRODUCT_SNACK  = 3'd6;
  localparam logic [ProductWidth-1:0] PRODUCT_CANDY  = 3'd7;

  // Online payments were never taken as cash, so nothing is refunded for them.
  function automatic logic [CoinWidth-1:0] refund_value(input logic [CoinWidth-1:0] coin,
                                                        input logic                 online);
    return online ? '0 : coin;
  endfunction

endpackage

// File: rtl/vend_session_arbiter_if.sv
// Bus between requester panels, the session arbiter and the VendingMachine core.
// master: the environment side (panels + core) driving requests and core status.
// slave : the arbiter, driving grants, completion results and core controls.
//   req/req_product/req_coin/req_online/req_abort : per-panel request data (flattened)
//   grant/done/done_ok/done_change/busy            : session ownership and results
//   vm_*                                           : core control and status
interface vend_session_arbiter_if
  import vend_session_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]              req;
  logic [ProductWidth*N_REQ-1:0] req_product;
  logic [CoinWidth*N_REQ-1:0]    req_coin;
  logic [N_REQ-1:0]              req_online;
  logic [N_REQ-1:0]              req_abort;

  logic [N_REQ-1:0]              grant;
  logic [N_REQ-1:0]              done;
  logic                          done_ok;
  logic [CoinWidth-1:0]          done_change;
  logic                          busy;

  logic                          vm_initiate;
  logic                          vm_abort;
  logic                          vm_payment_online;
  logic [ProductWidth-1:0]       vm_selected_product;
  logic [CoinWidth-1:0]          vm_coin_total_value;
  logic                          vm_dispense;
  logic [CoinWidth-1:0]          vm_change_to_return;
  logic [VmStateWidth-1:0]       vm_current_state;

  modport master (
    output req, req_product, req_coin, req_online, req_abort,
    output vm_dispense, vm_change_to_return, vm_current_state,
    input  grant, done, done_ok, done_change, busy,
    input  vm_initiate, vm_abort, vm_payment_online, vm_selected_product, vm_coin_total_value
  );

  modport slave (
    input  req, req_product, req_coin, req_online, req_abort,
    input  vm_dispense, vm_change_to_return, vm_current_state,
    output grant, done, done_ok, done_change, busy,
    output vm_initiate, vm_abort, vm_payment_online, vm_selected_product, vm_coin_total_value
  );

endinterface

// File: rtl/vend_session_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req        : requesting panels
//   last_grant : one-hot previous owner (all-zero treated as the top index)
//   pick       : one-hot winner, searching upward from last_grant+1 with wrap; zero if no req
module vend_session_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last_grant,
  output logic [N_REQ-1:0] pick
);

  int unsigned last_idx;
  logic        found;

  always_comb begin
    last_idx = N_REQ - 1;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (last_grant[i]) last_idx = i;
    end

    pick  = '0;
    found = 1'b0;
    // First pass covers indices above the last owner, second pass wraps to the bottom.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i > last_idx)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i <= last_idx)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one VendingMachine core among N_REQ requester panels, one session at a time.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : slave side of vend_session_arbiter_if (requests in, grant/done/core controls out)
// A session latches the winner's product/coin/online, pulses vm_initiate for INIT_CYCLES,
// then waits for dispense, owner abort or timeout, and reports the result with one done pulse.
module vend_session_arbiter
  import vend_session_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  vend_session_arbiter_if.slave bus
);

  localparam logic [N_REQ-1:0]      LastGrantRst = N_REQ'(1) << (N_REQ - 1);
  localparam logic [TimerWidth-1:0] InitLast     = TimerWidth'(INIT_CYCLES - 1);
  localparam logic [TimerWidth-1:0] TimeoutLast  = TimerWidth'(TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [N_REQ-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [N_REQ-1:0]        last_grant_q, last_grant_d;
  logic [ProductWidth-1:0] prod_q, prod_d;
  logic [CoinWidth-1:0]    coin_q, coin_d;
  logic                    online_q, online_d;
  logic [TimerWidth-1:0]   init_cnt_q, init_cnt_d;
  logic [TimerWidth-1:0]   tmo_q, tmo_d;
  logic                    abort_pend_q, abort_pend_d;
  logic                    done_ok_q, done_ok_d;
  logic [CoinWidth-1:0]    done_change_q, done_change_d;

  logic [N_REQ-1:0]        pick;
  logic [ProductWidth-1:0] sel_product;
  logic [CoinWidth-1:0]    sel_coin;
  logic                    sel_online;
  logic                    owner_abort;

  vend_session_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  // Request data of the chosen owner, sampled only in LATCH.
  always_comb begin
    sel_product = '0;
    sel_coin    = '0;
    sel_online  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q[i]) begin
        sel_product = bus.req_product[ProductWidth*i +: ProductWidth];
        sel_coin    = bus.req_coin[CoinWidth*i +: CoinWidth];
        sel_online  = bus.req_online[i];
      end
    end
  end

  // Only the current owner's cancel is ever looked at.
  assign owner_abort = |(bus.req_abort & grant_q);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    prod_d        = prod_q;
    coin_d        = coin_q;
    online_d      = online_q;
    init_cnt_d    = init_cnt_q;
    tmo_d         = tmo_q;
    abort_pend_d  = abort_pend_q;
    done_ok_d     = done_ok_q;
    done_change_d = done_change_q;

    unique case (state_q)
      StIdle: begin
        if ((|bus.req) && (bus.vm_current_state == VM_IDLE_STATE)) begin
          owner_d = pick;
          state_d = StLatch;
        end
      end
      StLatch: begin
        prod_d       = sel_product;
        coin_d       = sel_coin;
        online_d     = sel_online;
        grant_d      = owner_q;
        init_cnt_d   = '0;
        abort_pend_d = 1'b0;
        state_d      = StStart;
      end
      StStart: begin
        // A cancel during initiation is remembered and acted on once in WAIT.
        if (owner_abort) abort_pend_d = 1'b1;
        if (init_cnt_q == InitLast) begin
          tmo_d   = '0;
          state_d = StWait;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StWait: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
        // Dispense takes priority over any cancel or timeout in the same cycle.
        if (bus.vm_dispense) begin
          done_ok_d     = 1'b1;
          done_change_d = bus.vm_change_to_return;
          state_d       = StDone;
        end else if (owner_abort || abort_pend_q || (tmo_q >= TimeoutLast)) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (bus.vm_current_state == VM_IDLE_STATE) begin
          done_ok_d     = 1'b0;
          done_change_d = refund_value(coin_q, online_q);
          state_d       = StDone;
        end
      end
      StDone: begin
        last_grant_d = grant_q;
        grant_d      = '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      grant_q       <= '0;
      last_grant_q  <= LastGrantRst;
      prod_q        <= '0;
      coin_q        <= '0;
      online_q      <= 1'b0;
      init_cnt_q    <= '0;
      tmo_q         <= '0;
      abort_pend_q  <= 1'b0;
      done_ok_q     <= 1'b0;
      done_change_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      prod_q        <= prod_d;
      coin_q        <= coin_d;
      online_q      <= online_d;
      init_cnt_q    <= init_cnt_d;
      tmo_q         <= tmo_d;
      abort_pend_q  <= abort_pend_d;
      done_ok_q     <= done_ok_d;
      done_change_q <= done_change_d;
    end
  end

  assign bus.grant               = grant_q;
  assign bus.done                = (state_q == StDone) ? grant_q : '0;
  assign bus.done_ok             = done_ok_q;
  assign bus.done_change         = done_change_q;
  assign bus.busy                = (state_q != StIdle);
  assign bus.vm_initiate         = (state_q == StStart);
  assign bus.vm_abort            = (state_q == StAbort);
  assign bus.vm_payment_online   = online_q;
  assign bus.vm_selected_product = prod_q;
  assign bus.vm_coin_total_value = coin_q;

endmodule

// File: doc/vend_session_arbiter.md
VEND_SESSION_ARBITER -- requirements
Module: vend_session_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester panels sharing one VendingMachine core.
REQ-002 Parameter INIT_CYCLES, default 3, cycles vm_initiate is held high per session.
REQ-003 Parameter TIMEOUT, default 64, WAIT-state cycle limit before forced abort.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester session request, level.
REQ-007 req_product  input  3*N_REQ  flattened product codes, requester i at bits [3i+2:3i].
REQ-008 req_coin  input  7*N_REQ  flattened coin totals, requester i at bits [7i+6:7i].
REQ-009 req_online  input  N_REQ  per-requester online-payment flag.
REQ-010 req_abort  input  N_REQ  per-requester cancel; only the granted bit is honoured.
REQ-011 grant  output  N_REQ  one-hot owner of the core; zero when IDLE.
REQ-012 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-013 done_ok  output  1  valid with done: 1 dispensed, 0 aborted/timed out.
REQ-014 done_change  output  7  valid with done: change or refund value.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 vm_initiate, vm_abort, vm_payment_online  output  1 each  drive the core.
REQ-017 vm_selected_product  output  3; vm_coin_total_value  output  7  drive the core.
REQ-018 vm_dispense  input  1; vm_change_to_return  input  7; vm_current_state  input  4 (0 = core idle).

Function
REQ-019 FSM states IDLE, LATCH, START, WAIT, ABORT, DONE; one-hot or binary encoding at implementer's choice.
REQ-020 IDLE: when any req bit high and vm_current_state==0, select winner by round-robin starting at (last_grant+1) mod N_REQ; go LATCH.
REQ-021 LATCH (1 cycle): register winner's product, coin, online into session registers; set grant one-hot; go START.
REQ-022 Session registers drive vm_* data outputs throughout; later changes on req_* data are ignored.
REQ-023 START: vm_initiate=1 for exactly INIT_CYCLES cycles, then WAIT.
REQ-024 WAIT: vm_dispense high -> capture vm_change_to_return, ok=1, go DONE.
REQ-025 WAIT: granted req_abort high or timeout counter reaches TIMEOUT -> go ABORT.
REQ-026 Dispense and abort/timeout in the same cycle: dispense wins.
REQ-027 req_abort during START is held pending and takes effect on first WAIT cycle unless dispense occurs there.
REQ-028 ABORT: vm_abort=1 until vm_current_state==0 (minimum 1 cycle); refund = session coin if not online, else 0; ok=0; go DONE.
REQ-029 DONE (1 cycle): done[owner]=1, done_ok/done_change driven; last_grant<=owner; grant cleared next cycle; go IDLE.
REQ-030 Owner dropping req mid-session does not end the session.
REQ-031 Non-granted req_abort bits never affect the core.
REQ-032 Timeout counter: 8 bits, cleared on WAIT entry, saturating.
REQ-033 done_ok/done_change hold last value outside DONE; only done qualifies them.

Reset
REQ-034 rst low asynchronously forces IDLE; grant, done, done_ok, busy, vm_initiate, vm_abort, vm_payment_online = 0.
REQ-035 Reset values: vm_selected_product=0, vm_coin_total_value=0, done_change=0, timeout counter=0, last_grant=N_REQ-1 (requester 0 first).
REQ-036 Reset mid-session abandons it with no done pulse.

Structure
REQ-037 Shared package holds state encoding constants, VM_IDLE_STATE=0, and product code constants shared with VendingMachine.
REQ-038 One sub-module: rr_pick (combinational round-robin selector, inputs req and last_grant, output one-hot).

Verification
REQ-039 req=0001, product 001, coin 50; core dispenses with change 30 -> grant=0001, vm_initiate high 3 cycles, done=0001, done_ok=1, done_change=30.
REQ-040 req=1111 held continuously for four sessions -> grants in order 0001,0010,0100,1000.
REQ-041 Owner 2, coin 50, offline, req_abort[2] in WAIT -> vm_abort asserted until core state 0, done=0100, done_ok=0, done_change=50.
REQ-042 Core never dispenses -> after 64 WAIT cycles ABORT entered, done_ok=0; with online=1, done_change=0.
REQ-043 vm_dispense and req_abort same cycle, change 10 -> done_ok=1, done_change=10, vm_abort never asserted.
REQ-044 rst low during WAIT -> all outputs at reset values immediately, no done pulse, next grant to requester 0.
